i2c_byte_receiver: RTL and testbench
====================================

# i2c_byte_receiver

Responder-side byte receiver for the I2C controller, the counterpart of the SCL-generating clock divisor on the initiator side. It samples raw SCL/SDA with the system clock and filters glitches. It detects START, repeated START and STOP conditions, shifts in 8 data bits MSB first, and drives the 9th-bit ACK on SDA through an open-drain enable. Received bytes and bus events go to the upstream controller as single-cycle pulses.

## Interface
- FILTER_LEN, 3: consecutive identical synchronized samples required before a filtered SCL/SDA level changes (1..15).
- clk_i  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  block enable; low forces IDLE and releases SDA.
- scl_i  in  1  raw SCL from pad.
- sda_i  in  1  raw SDA from pad.
- ack_en  in  1  1 = ACK the current byte, 0 = NACK; sampled at the 8th-bit SCL falling edge.
- sda_oe  out  1  1 = pull SDA low (ACK); 0 = released.
- rx_data  out  8  last received byte; holds until the next byte completes.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- start_det  out  1  one-cycle pulse on START or repeated START.
- stop_det  out  1  one-cycle pulse on STOP.
- busy  out  1  high from START until STOP.
- bit_cnt  out  4  current bit index, 0..8 (8 = ACK slot).

## Operation
- Input path: 2-flop synchronizer per line, then glitch filter. Filter registers reset to 1 (idle bus). Filtered edges come from comparing the filter output with its previous value.
- START: filtered SDA falls while filtered SCL is high and stable. STOP: filtered SDA rises while filtered SCL is high and stable.
- If filtered SCL and filtered SDA change in the same cycle, the SCL edge wins and no START/STOP is flagged.
- States:
  - IDLE: bit_cnt=0, busy=0. START -> RX.
  - RX: each filtered SCL rising edge shifts SDA into the shift register MSB first and increments bit_cnt. On the rise that samples bit 7 (LSB), rx_data loads and rx_valid pulses; bit_cnt becomes 8. On the following SCL falling edge -> ACK.
  - ACK: on entry, sda_oe = ack_en. sda_oe holds through SCL high. On the next SCL falling edge, sda_oe=0 and bit_cnt=0. Then -> RX if ACKed, or -> WAIT if NACKed.
  - WAIT: ignores SCL edges; sda_oe=0; only START or STOP leave it.
- Repeated START in RX, ACK or WAIT: start_det pulses, sda_oe=0, shift register and bit_cnt clear, -> RX.
- STOP in any non-IDLE state: stop_det pulses, sda_oe=0 in the same cycle, partial byte discarded, -> IDLE.
- STOP in IDLE: stop_det pulses; state stays IDLE.
- en low: next cycle state=IDLE, sda_oe=0, no pulses. Filters keep running.
- en rising mid-transfer: stays IDLE until a START.
- Reset values: sda_oe=0, rx_data=8'h00, rx_valid=0, start_det=0, stop_det=0, busy=0, bit_cnt=0, state=IDLE.

## Timing
- Pad-to-filtered latency: 2 + FILTER_LEN cycles.
- State, bit_cnt, busy and the output pulses update on the cycle after the filtered edge registers.
- rx_valid/rx_data: 1 cycle after the filtered SCL rise that samples bit 7.
- sda_oe assert: 1 cycle after the filtered 8th-bit SCL fall.
- sda_oe release: 1 cycle after the filtered 9th-bit SCL fall.
- Required bus timing: SCL high and SCL low each at least FILTER_LEN + 4 clk_i cycles. SDA setup/hold around SCL edges at least FILTER_LEN + 2 cycles.
- Pulses never exceed one cycle. Back-to-back bytes give rx_valid pulses separated by the bus byte time.

## Structure
- Shared package i2c_pkg:
  - state enum (IDLE, RX, ACK, WAIT)
  - I2C_BYTE_BITS = 8
  - I2C_ACK_BIT = 8
  - default FILTER_LEN
- Sub-module i2c_glitch_filter (synchronizer + saturating sample counter, reset output 1), instantiated once for SCL and once for SDA. The clock divisor can reuse it later for clock-stretch detection.

## Test plan
- Reset, lines high, FILTER_LEN=3 -> all outputs zero. START then byte 8'hA5 with ack_en=1 -> start_det pulse, busy=1, rx_data=8'hA5, one rx_valid pulse, sda_oe=1 exactly across the 9th SCL high, bit_cnt returns to 0.
- Byte 8'h3C with ack_en=0 -> rx_valid with 8'h3C, sda_oe stays 0. Further SCL clocking -> no rx_valid until a START or STOP.
- Two bytes 8'h01, 8'hFF, then STOP -> two rx_valid pulses, stop_det pulse, busy=0, state IDLE.
- Repeated START after bit 4 of a byte -> start_det pulse, bit_cnt=0. Next full byte 8'h5A received correctly; partial byte never reported.
- 2-cycle SDA glitch while SCL high (FILTER_LEN=3) -> no start_det/stop_det. 2-cycle SCL glitch mid-bit -> bit_cnt unchanged.
- en dropped while sda_oe=1 in the ACK slot -> sda_oe=0 next cycle, state IDLE.
- Async rst_n asserted mid-byte -> immediate return to reset values; after release, START and 8'hC3 receive normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C responder-side receive path.
// Holds the FSM state encoding, byte geometry and line-event helper.
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RX   = 2'd1,
        ACK  = 2'd2,
        WAIT = 2'd3
    } i2c_state_e;

    localparam int I2C_BYTE_BITS  = 8;
    localparam int I2C_ACK_BIT    = 8;
    localparam int I2C_FILTER_LEN = 3;

    typedef struct packed {
        logic rise;
        logic fall;
        logic chg;
    } line_ev_t;

    function automatic line_ev_t line_events(
        input logic cur,
        input logic prev
    );
        line_ev_t ev;
        ev.rise = cur & ~prev;
        ev.fall = ~cur & prev;
        ev.chg  = cur ^ prev;
        return ev;
    endfunction

endpackage

// File: rtl/i2c_byte_receiver_if.sv
// Pad-side inputs and upstream-facing outputs of the byte receiver.
// The master side drives the bus lines and the per-byte ACK choice.
interface i2c_byte_receiver_if;

    logic       en;
    logic       scl_i;
    logic       sda_i;
    logic       ack_en;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       start_det;
    logic       stop_det;
    logic       busy;
    logic [3:0] bit_cnt;

    modport master (
        output en,
        output scl_i,
        output sda_i,
        output ack_en,
        input  sda_oe,
        input  rx_data,
        input  rx_valid,
        input  start_det,
        input  stop_det,
        input  busy,
        input  bit_cnt
    );

    modport slave (
        input  en,
        input  scl_i,
        input  sda_i,
        input  ack_en,
        output sda_oe,
        output rx_data,
        output rx_valid,
        output start_det,
        output stop_det,
        output busy,
        output bit_cnt
    );

endinterface

// File: rtl/i2c_glitch_filter.sv
// Two-flop synchronizer followed by a saturating agreement counter.
// Output flips only after FILTER_LEN consecutive differing samples.
module i2c_glitch_filter
    import i2c_pkg::*;
#(
    parameter int FILTER_LEN = I2C_FILTER_LEN
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic line_i,
    output logic line_o
);

    localparam logic [3:0] CNT_MAX = 4'(FILTER_LEN - 1);

    logic [1:0] sync_q;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       line_q;
    logic       line_d;

    always_comb begin
        cnt_d  = '0;
        line_d = line_q;
        if (sync_q[1] != line_q) begin
            if (cnt_q == CNT_MAX) begin
                line_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // Reset to 1 so an idle (pulled-up) bus never looks like an edge.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            line_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], line_i};
            cnt_q  <= cnt_d;
            line_q <= line_d;
        end
    end

    assign line_o = line_q;

endmodule

// File: rtl/i2c_byte_receiver.sv
// Responder-side I2C byte receiver: START/STOP detect, 8-bit
// MSB-first shift-in and open-drain ACK drive in the 9th slot.
module i2c_byte_receiver
    import i2c_pkg::*;
#(
    parameter int FILTER_LEN = I2C_FILTER_LEN
) (
    input logic                clk_i,
    input logic                rst_n,
    i2c_byte_receiver_if.slave bus
);

    localparam logic [3:0] ACK_IDX = 4'(I2C_ACK_BIT);
    localparam logic [3:0] LSB_IDX = 4'(I2C_BYTE_BITS - 1);

    logic       scl_f;
    logic       sda_f;
    logic       scl_prev_q;
    logic       sda_prev_q;
    line_ev_t   scl_ev;
    line_ev_t   sda_ev;
    logic       start_ev;
    logic       stop_ev;

    i2c_state_e state_q;
    logic [7:0] shift_q;
    logic [7:0] shift_nx;
    logic [3:0] bit_cnt_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       start_q;
    logic       stop_q;
    logic       busy_q;
    logic       sda_oe_q;
    logic       acked_q;

    i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .line_i (bus.scl_i),
        .line_o (scl_f)
    );

    i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .line_i (bus.sda_i),
        .line_o (sda_f)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_f;
            sda_prev_q <= sda_f;
        end
    end

    assign scl_ev = line_events(scl_f, scl_prev_q);
    assign sda_ev = line_events(sda_f, sda_prev_q);

    // A simultaneous SCL edge wins: SDA moving then is not a condition.
    assign start_ev = sda_ev.fall & scl_f & ~scl_ev.chg;
    assign stop_ev  = sda_ev.rise & scl_f & ~scl_ev.chg;

    assign shift_nx = {shift_q[6:0], sda_f};

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            busy_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            acked_q    <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            if (!bus.en) begin
                state_q   <= IDLE;
                shift_q   <= '0;
                bit_cnt_q <= '0;
                busy_q    <= 1'b0;
                sda_oe_q  <= 1'b0;
            end else if (stop_ev) begin
                state_q   <= IDLE;
                shift_q   <= '0;
                bit_cnt_q <= '0;
                busy_q    <= 1'b0;
                sda_oe_q  <= 1'b0;
                stop_q    <= 1'b1;
            end else if (start_ev) begin
                state_q   <= RX;
                shift_q   <= '0;
                bit_cnt_q <= '0;
                busy_q    <= 1'b1;
                sda_oe_q  <= 1'b0;
                start_q   <= 1'b1;
            end else begin
                case (state_q)
                    RX: begin
                        if (scl_ev.rise && bit_cnt_q != ACK_IDX) begin
                            shift_q   <= shift_nx;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == LSB_IDX) begin
                                rx_data_q  <= shift_nx;
                                rx_valid_q <= 1'b1;
                            end
                        end else if (scl_ev.fall &&
                                     bit_cnt_q == ACK_IDX) begin
                            state_q  <= ACK;
                            sda_oe_q <= bus.ack_en;
                            acked_q  <= bus.ack_en;
                        end
                    end
                    ACK: begin
                        if (scl_ev.fall) begin
                            sda_oe_q  <= 1'b0;
                            bit_cnt_q <= '0;
                            shift_q   <= '0;
                            state_q   <= acked_q ? RX : WAIT;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.sda_oe    = sda_oe_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.start_det = start_q;
    assign bus.stop_det  = stop_q;
    assign bus.busy      = busy_q;
    assign bus.bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_i2c_byte_receiver.sv
// Directed plus randomized bus transactions for i2c_byte_receiver,
// checked against a transaction-level model of the responder.
module tb_i2c_byte_receiver;

    localparam int FL = 3;
    localparam int H  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    int start_cnt  = 0;
    int stop_cnt   = 0;
    int long_pulse = 0;
    logic pv_rx = 1'b0;
    logic pv_st = 1'b0;
    logic pv_sp = 1'b0;
    logic [7:0] rx_q[$];

    int exp_start = 0;
    int exp_stop  = 0;
    bit listen    = 1'b0;

    i2c_byte_receiver_if bus();

    assign bus.scl_i = scl_m;
    assign bus.sda_i = sda_m & ~bus.sda_oe;

    i2c_byte_receiver #(.FILTER_LEN(FL)) dut (
        .clk_i (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) rx_q.push_back(bus.rx_data);
        if (bus.start_det === 1'b1) start_cnt <= start_cnt + 1;
        if (bus.stop_det === 1'b1) stop_cnt <= stop_cnt + 1;
        if ((pv_rx && bus.rx_valid) || (pv_st && bus.start_det) ||
            (pv_sp && bus.stop_det))
            long_pulse <= long_pulse + 1;
        pv_rx <= (bus.rx_valid === 1'b1);
        pv_st <= (bus.start_det === 1'b1);
        pv_sp <= (bus.stop_det === 1'b1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_events(input string tag);
        chk({tag, "_start"}, start_cnt, exp_start);
        chk({tag, "_stop"}, stop_cnt, exp_stop);
    endtask

    task automatic do_start();
        sda_m = 1'b1;
        scl_m = 1'b1;
        cyc(H);
        sda_m = 1'b0;
        cyc(H);
        scl_m = 1'b0;
        cyc(H);
        exp_start++;
        listen = 1'b1;
        chk_events("start");
        chk("start_busy", 32'(bus.busy), 32'd1);
        chk("start_bitcnt", 32'(bus.bit_cnt), 32'd0);
    endtask

    task automatic do_rstart();
        sda_m = 1'b1;
        cyc(H);
        scl_m = 1'b1;
        cyc(H);
        sda_m = 1'b0;
        cyc(H);
        scl_m = 1'b0;
        cyc(H);
        exp_start++;
        listen = 1'b1;
        chk_events("rstart");
        chk("rstart_bitcnt", 32'(bus.bit_cnt), 32'd0);
        chk("rstart_oe", 32'(bus.sda_oe), 32'd0);
    endtask

    task automatic do_stop();
        sda_m = 1'b0;
        cyc(H);
        scl_m = 1'b1;
        cyc(H);
        sda_m = 1'b1;
        cyc(H);
        exp_stop++;
        listen = 1'b0;
        chk_events("stop");
        chk("stop_busy", 32'(bus.busy), 32'd0);
        chk("stop_bitcnt", 32'(bus.bit_cnt), 32'd0);
        chk("stop_oe", 32'(bus.sda_oe), 32'd0);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;
        cyc(H);
        scl_m = 1'b1;
        cyc(H);
        scl_m = 1'b0;
        cyc(H);
    endtask

    task automatic check_rx(input logic [7:0] b);
        if (listen) begin
            chk("rx_count", rx_q.size(), 32'd1);
            if (rx_q.size() > 0) chk("rx_data", 32'(rx_q.pop_front()), 32'(b));
        end else begin
            chk("rx_none", rx_q.size(), 32'd0);
        end
        rx_q.delete();
    endtask

    task automatic byte_tail(input logic [7:0] b, input logic a);
        logic oe_exp;
        oe_exp = listen & a;
        check_rx(b);
        chk("oe_set", 32'(bus.sda_oe), 32'(oe_exp));
        sda_m = 1'b1;
        cyc(H);
        scl_m = 1'b1;
        cyc(H / 2);
        chk("oe_high", 32'(bus.sda_oe), 32'(oe_exp));
        chk("ack_bitcnt", 32'(bus.bit_cnt), listen ? 32'd8 : 32'd0);
        cyc(H / 2);
        scl_m = 1'b0;
        cyc(H);
        chk("oe_rel", 32'(bus.sda_oe), 32'd0);
        chk("post_bitcnt", 32'(bus.bit_cnt), 32'd0);
        listen = listen & a;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic a);
        bus.ack_en = a;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        byte_tail(b, a);
    endtask

    initial begin
        logic [7:0] v;
        int op;
        bus.en     = 1'b1;
        bus.ack_en = 1'b0;
        rst_n      = 1'b0;
        cyc(3);
        chk("rst_oe", 32'(bus.sda_oe), 32'd0);
        chk("rst_data", 32'(bus.rx_data), 32'd0);
        chk("rst_valid", 32'(bus.rx_valid), 32'd0);
        chk("rst_start", 32'(bus.start_det), 32'd0);
        chk("rst_stop", 32'(bus.stop_det), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_bitcnt", 32'(bus.bit_cnt), 32'd0);
        rst_n = 1'b1;
        cyc(10);
        chk_events("post_rst");

        do_start();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b0);
        send_byte(8'(($urandom)), 1'b1);
        do_stop();

        do_start();
        send_byte(8'h01, 1'b1);
        send_byte(8'hFF, 1'b1);
        do_stop();

        do_start();
        v = 8'($urandom);
        for (int i = 7; i >= 4; i--) send_bit(v[i]);
        do_rstart();
        send_byte(8'h5A, 1'b1);

        v = 8'h96;
        bus.ack_en = 1'b1;
        for (int i = 7; i >= 5; i--) send_bit(v[i]);
        scl_m = 1'b1;
        cyc(2);
        scl_m = 1'b0;
        cyc(H);
        chk("scl_glitch_bitcnt", 32'(bus.bit_cnt), 32'd3);
        for (int i = 4; i >= 0; i--) send_bit(v[i]);
        byte_tail(v, 1'b1);
        do_stop();

        sda_m = 1'b0;
        cyc(2);
        sda_m = 1'b1;
        cyc(H);
        chk_events("sda_glitch");
        chk("sda_glitch_busy", 32'(bus.busy), 32'd0);

        do_start();
        v = 8'($urandom);
        bus.ack_en = 1'b1;
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        check_rx(v);
        sda_m = 1'b1;
        cyc(H);
        scl_m = 1'b1;
        cyc(3);
        chk("en_oe_before", 32'(bus.sda_oe), 32'd1);
        bus.en = 1'b0;
        cyc(1);
        chk("en_oe_after", 32'(bus.sda_oe), 32'd0);
        chk("en_busy", 32'(bus.busy), 32'd0);
        chk("en_bitcnt", 32'(bus.bit_cnt), 32'd0);
        cyc(H);
        scl_m = 1'b0;
        cyc(H);
        bus.en = 1'b1;
        listen = 1'b0;
        chk_events("en_low");
        send_byte(8'($urandom), 1'b1);
        do_stop();

        do_start();
        for (int k = 0; k < 10; k++) begin
            op = int'($urandom_range(0, 5));
            if (op == 0) begin
                do_rstart();
            end else if (op == 1) begin
                do_stop();
                do_start();
            end else begin
                send_byte(8'($urandom), 1'($urandom_range(0, 3) != 0));
            end
        end
        do_stop();

        do_start();
        v = 8'($urandom);
        for (int i = 7; i >= 5; i--) send_bit(v[i]);
        rst_n = 1'b0;
        #1;
        chk("arst_bitcnt", 32'(bus.bit_cnt), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_oe", 32'(bus.sda_oe), 32'd0);
        chk("arst_data", 32'(bus.rx_data), 32'd0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        cyc(4);
        rst_n = 1'b1;
        cyc(H);
        listen = 1'b0;
        rx_q.delete();
        chk_events("arst_release");
        do_start();
        send_byte(8'hC3, 1'b1);
        do_stop();

        chk("pulse_width", long_pulse, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
